// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer driving one shared BCD digit adder.
// Operands are latched on Start and fed LSD first; the decimal carry ripples through a register.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic [3:0]          DigA,
  output logic [3:0]          DigB,
  output logic                DigCin,
  input  logic [3:0]          DigSum,
  input  logic                DigCout,
  output logic [4*DIGITS-1:0] Sum,
  output logic                Cout,
  output logic                Busy,
  output logic                Done,
  output logic                Err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  sum_q;
  logic          carry;
  logic          cout_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          bad;
  logic          last;

  function automatic logic bad_digits(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  assign bad  = bad_digits(A) | bad_digits(B);
  assign last = (cnt == LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (Start) state_nx = bad ? DONE : ADD;
      ADD:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state != IDLE);
    Done   = (state == DONE);
    DigA   = 4'd0;
    DigB   = 4'd0;
    DigCin = 1'b0;
    if (state == ADD) begin
      DigA   = a_sh[3:0];
      DigB   = b_sh[3:0];
      DigCin = carry;
    end
  end

  // Result digits enter at the top so the first digit lands at [3:0] after DIGITS shifts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start && bad) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b1;
          end else if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
            err_q <= 1'b0;
          end
        end
        ADD: begin
          sum_q <= (sum_q >> 4) | (W'(DigSum) << (W - 4));
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          carry <= DigCout;
          cnt   <= cnt + CW'(1);
          if (last) cout_q <= DigCout;
        end
        default: ;
      endcase
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Err  = err_q;

endmodule
